// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: resolves branch flushes, load-use stalls and
// memory freezes into PC/IF-ID/ID-EX enables, with a memory-timeout halt state.
module pipe_hazard_ctl #(
    parameter int FLUSH_CYC   = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel,
    input  logic        load_use,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        stall,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] FLUSH   = 2'd1;
    localparam logic [1:0] LDSTALL = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);
    localparam logic [7:0] TO_LAST    = 8'(MEM_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  fl_cnt_q, fl_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic pc_en_c, ifid_en_c, idex_en_c, ifid_fl_c, idex_fl_c;

    // Safe defaults (everything held, both registers bubbled) cover reset and HALT.
    always_comb begin
        state_d   = state_q;
        fl_cnt_d  = fl_cnt_q;
        to_cnt_d  = 8'd0;
        mem_err_d = 1'b0;
        pc_en_c   = 1'b0;
        ifid_en_c = 1'b0;
        idex_en_c = 1'b0;
        ifid_fl_c = 1'b1;
        idex_fl_c = 1'b1;

        if (rst || state_q == HALT) begin
            state_d = state_q;
        end else if (mem_busy) begin
            ifid_fl_c = 1'b0;
            idex_fl_c = 1'b0;
            to_cnt_d  = to_cnt_q + 8'd1;
            if (to_cnt_q == TO_LAST) begin
                state_d   = HALT;
                mem_err_d = 1'b1;
            end
        end else begin
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
            idex_en_c = 1'b1;
            ifid_fl_c = 1'b0;
            idex_fl_c = 1'b0;
            if (state_q == FLUSH) begin
                ifid_fl_c = 1'b1;
                fl_cnt_d  = fl_cnt_q - 2'd1;
                if (fl_cnt_q == 2'd1) begin
                    state_d = RUN;
                end
            end else if (pc_sel) begin
                ifid_fl_c = 1'b1;
                idex_fl_c = 1'b1;
                state_d   = RUN;
                if (FLUSH_CYC > 1) begin
                    fl_cnt_d = FLUSH_INIT;
                    state_d  = FLUSH;
                end
            end else if (load_use && state_q == RUN) begin
                // Hold PC and IF/ID, push a bubble into EX behind the load.
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
                idex_fl_c = 1'b1;
                state_d   = LDSTALL;
            end else begin
                state_d = RUN;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en_c && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            fl_cnt_q    <= 2'd0;
            to_cnt_q    <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            fl_cnt_q    <= fl_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_en      = pc_en_c;
    assign ifid_en    = ifid_en_c;
    assign idex_en    = idex_en_c;
    assign ifid_flush = ifid_fl_c;
    assign idex_flush = idex_fl_c;
    assign stall      = ~pc_en_c;
    assign mem_err    = mem_err_q;
    assign stall_cnt  = stall_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scenario bench for pipe_hazard_ctl: two parameterisations share one stimulus bus.
module tb_pipe_hazard_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pc_sel = 1'b0;
    logic load_use = 1'b0;
    logic mem_busy = 1'b0;

    logic        a_pc_en, a_ifid_en, a_idex_en, a_ifid_fl, a_idex_fl, a_stall, a_mem_err;
    logic [15:0] a_sc;
    logic [1:0]  a_state;
    logic        b_pc_en, b_ifid_en, b_idex_en, b_ifid_fl, b_idex_fl, b_stall, b_mem_err;
    logic [15:0] b_sc;
    logic [1:0]  b_state;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.FLUSH_CYC(2), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .load_use(load_use), .mem_busy(mem_busy),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
        .ifid_flush(a_ifid_fl), .idex_flush(a_idex_fl), .stall(a_stall),
        .mem_err(a_mem_err), .stall_cnt(a_sc), .state(a_state)
    );

    pipe_hazard_ctl #(.FLUSH_CYC(3), .MEM_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .load_use(load_use), .mem_busy(mem_busy),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .ifid_flush(b_ifid_fl), .idex_flush(b_idex_fl), .stall(b_stall),
        .mem_err(b_mem_err), .stall_cnt(b_sc), .state(b_state)
    );

    // Observed vector: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, stall, mem_err, state}
    logic [8:0] obs_a, obs_b;
    assign obs_a = {a_pc_en, a_ifid_en, a_idex_en, a_ifid_fl, a_idex_fl, a_stall, a_mem_err, a_state};
    assign obs_b = {b_pc_en, b_ifid_en, b_idex_en, b_ifid_fl, b_idex_fl, b_stall, b_mem_err, b_state};

    // Stimulus codes {rst, pc_sel, load_use, mem_busy}
    localparam logic [3:0] S_RST = 4'b1000;
    localparam logic [3:0] S_0   = 4'b0000;
    localparam logic [3:0] S_PS  = 4'b0100;
    localparam logic [3:0] S_LU  = 4'b0010;
    localparam logic [3:0] S_MB  = 4'b0001;
    localparam logic [3:0] S_PL  = 4'b0110;
    localparam logic [3:0] S_PM  = 4'b0101;
    localparam logic [3:0] S_LM  = 4'b0011;

    localparam logic [8:0] V_RST    = 9'b000_11_1_0_00;
    localparam logic [8:0] V_NORM   = 9'b111_00_0_0_00;
    localparam logic [8:0] V_BR     = 9'b111_11_0_0_00;
    localparam logic [8:0] V_BR_LD  = 9'b111_11_0_0_10;
    localparam logic [8:0] V_FL     = 9'b111_10_0_0_01;
    localparam logic [8:0] V_LS     = 9'b001_01_1_0_00;
    localparam logic [8:0] V_LDS    = 9'b111_00_0_0_10;
    localparam logic [8:0] V_FZ0    = 9'b000_00_1_0_00;
    localparam logic [8:0] V_FZ1    = 9'b000_00_1_0_01;
    localparam logic [8:0] V_FZ2    = 9'b000_00_1_0_10;
    localparam logic [8:0] V_HALT_E = 9'b000_11_1_1_11;
    localparam logic [8:0] V_HALT   = 9'b000_11_1_0_11;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_sc = 16'd0;
    logic [24:0] sb_q[$];

    // Expected stall count follows the expected stall bit, cleared by reset.
    task automatic push_exp(input logic [3:0] s, input logic [8:0] v);
        if (s[3]) exp_sc = 16'd0;
        sb_q.push_back({v, exp_sc});
        if (!s[3] && v[3] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    endtask

    task automatic drive(input logic [3:0] s);
        @(posedge clk);
        #1;
        {rst, pc_sel, load_use, mem_busy} = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [12:0] t [5];
        logic [24:0] e, got;
        t = '{{S_RST, V_RST}, {S_RST, V_RST}, {S_0, V_NORM}, {S_0, V_NORM}, {S_0, V_NORM}};
        for (int i = 0; i < 5; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_a, a_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL reset[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    task automatic test_branch;
        logic [12:0] t [6];
        logic [24:0] e, got;
        t = '{{S_PS, V_BR}, {S_0, V_FL}, {S_0, V_NORM},
              {S_PS, V_BR}, {S_PL, V_FL}, {S_0, V_NORM}};
        for (int i = 0; i < 6; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_a, a_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL branch[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    task automatic test_load_use;
        logic [12:0] t [7];
        logic [24:0] e, got;
        t = '{{S_LU, V_LS}, {S_LU, V_LDS}, {S_0, V_NORM},
              {S_LU, V_LS}, {S_PS, V_BR_LD}, {S_0, V_FL}, {S_0, V_NORM}};
        for (int i = 0; i < 7; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_a, a_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL load_use[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    task automatic test_priority;
        logic [12:0] t [7];
        logic [24:0] e, got;
        t = '{{S_PL, V_BR}, {S_0, V_FL}, {S_0, V_NORM},
              {S_PM, V_FZ0}, {S_0, V_NORM}, {S_LM, V_FZ0}, {S_0, V_NORM}};
        for (int i = 0; i < 7; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_a, a_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL priority[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    // Observes the FLUSH_CYC=3 instance.
    task automatic test_flush_freeze;
        logic [12:0] t [12];
        logic [24:0] e, got;
        t = '{{S_RST, V_RST}, {S_PS, V_BR}, {S_MB, V_FZ1}, {S_PM, V_FZ1}, {S_MB, V_FZ1},
              {S_0, V_FL}, {S_PL, V_FL}, {S_0, V_NORM},
              {S_LU, V_LS}, {S_MB, V_FZ2}, {S_LU, V_LDS}, {S_0, V_NORM}};
        for (int i = 0; i < 12; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_b, b_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL flush_freeze[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout;
        logic [12:0] t [17];
        logic [24:0] e, got;
        t = '{{S_RST, V_RST},
              {S_MB, V_FZ0}, {S_MB, V_FZ0}, {S_MB, V_FZ0}, {S_0, V_NORM},
              {S_MB, V_FZ0}, {S_MB, V_FZ0}, {S_MB, V_FZ0}, {S_0, V_NORM},
              {S_MB, V_FZ0}, {S_MB, V_FZ0}, {S_MB, V_FZ0}, {S_MB, V_FZ0},
              {S_PS, V_HALT_E}, {S_LU, V_HALT}, {S_0, V_HALT}, {S_MB, V_HALT}};
        for (int i = 0; i < 17; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_a, a_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL timeout[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort;
        logic [12:0] t [8];
        logic [24:0] e, got;
        t = '{{S_RST, V_RST}, {S_0, V_NORM}, {S_PS, V_BR}, {S_RST, V_RST},
              {S_0, V_NORM}, {S_MB, V_FZ0}, {S_RST, V_RST}, {S_0, V_NORM}};
        for (int i = 0; i < 8; i++) begin
            push_exp(t[i][12:9], t[i][8:0]);
            drive(t[i][12:9]);
            e = sb_q.pop_front();
            got = {obs_a, a_sc};
            n_checks++;
            if (got !== e)
                $display("FAIL reset_abort[%0d]: got vec=%b stall_cnt=%0d, expected vec=%b stall_cnt=%0d",
                         i, got[24:16], got[15:0], e[24:16], e[15:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_use();
        test_priority();
        test_flush_freeze();
        test_timeout();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
